// File: rtl/fpu_csr_pkg.sv
// Shared definitions for the FPU CSR bank: register offsets, STATUS bit positions
// and the result-queue entry layout.
package fpu_csr_pkg;

    localparam logic [31:0] OFF_OPERAND0  = 32'h00;
    localparam logic [31:0] OFF_RESULT    = 32'h20;
    localparam logic [31:0] OFF_RES_INFO  = 32'h24;
    localparam logic [31:0] OFF_OPERATION = 32'h28;
    localparam logic [31:0] OFF_STATUS    = 32'h2C;
    localparam logic [31:0] OFF_IRQ_EN    = 32'h30;
    localparam logic [31:0] OFF_FFLAGS    = 32'h34;
    localparam logic [31:0] OFF_FRM       = 32'h38;
    localparam logic [31:0] OFF_FCSR      = 32'h3C;
    localparam logic [31:0] OFF_LEVEL     = 32'h40;

    localparam int ST_DONE      = 0;
    localparam int ST_OVERFLOW  = 1;
    localparam int ST_UNDERFLOW = 2;
    localparam int ST_OP_ERR    = 3;
    localparam int ST_BUSY      = 4;

    // op_id is stored at full RES_INFO width; NUM_FUNCS up to 23 fits bits [30:8].
    localparam int OP_ID_W = 23;

    typedef struct packed {
        logic [31:0]        result;
        logic [4:0]         exc;
        logic [OP_ID_W-1:0] op_id;
    } res_entry_t;

endpackage

// File: rtl/fpu_csr_bank_if.sv
// Host register bus between the Wishbone slave decode and the FPU CSR bank.
interface fpu_csr_bank_if;
    logic [31:0] addr;
    logic        wren;
    logic        rden;
    logic [31:0] wrdata;
    logic [31:0] rddata;

    modport master (output addr, wren, rden, wrdata, input rddata);
    modport slave  (input addr, wren, rden, wrdata, output rddata);
endinterface

// File: rtl/fpu_res_fifo.sv
// Result queue for the FPU CSR bank; wrap-around pointers carry an extra MSB to
// tell full from empty. Pushes while full without a pop are dropped.
module fpu_res_fifo
    import fpu_csr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  res_entry_t             wdata_i,
    output res_entry_t             rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);

    res_entry_t  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push_i && (!full_o || pop_i);

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/fpu_csr_bank.sv
// Memory-mapped control/status bank for the FPU wrapper: operands, launch, result queue,
// fflags/frm and irq. Define FPU_RES_FIFO_EN for a RES_DEPTH-entry queue, else one holding entry.
module fpu_csr_bank
    import fpu_csr_pkg::*;
#(
    parameter logic [31:0]          BASE_ADDR = 32'h3000_0000,
    parameter int                   NUM_OPS   = 3,
    parameter int                   NUM_FUNCS = 13,
    parameter logic [NUM_FUNCS-1:0] RES_MASK  = 13'h1FFC,
    parameter int                   RES_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    fpu_csr_bank_if.slave         bus,
    output logic [NUM_OPS*32-1:0] ops,
    output logic [NUM_FUNCS-1:0]  op_valids,
    output logic [2:0]            frm,
    input  logic [31:0]           fpu_result,
    input  logic [NUM_FUNCS-1:0]  fpu_valids,
    input  logic [4:0]            exceptions,
    output logic                  busy,
    output logic                  irq
);
    localparam int LVL_W = $clog2(RES_DEPTH) + 1;

    logic [31:0]          off;
    logic [31:0]          ops_q [NUM_OPS];
    logic [31:0]          ops_d [NUM_OPS];
    logic [NUM_FUNCS-1:0] op_valids_q, op_valids_d;
    logic                 busy_q, busy_d;
    logic [2:0]           frm_q, frm_d;
    logic [4:0]           fflags_q, fflags_d;
    logic [3:0]           irq_en_q, irq_en_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;
    logic                 op_err_q, op_err_d;

    logic [NUM_FUNCS-1:0] op_sel;
    logic                 op_onehot, launch, op_err_set;
    logic                 push, pop_req, pop, empty, ovf_set;
    logic [3:1]           w1c;
    logic [LVL_W-1:0]     level;
    res_entry_t           push_entry, head;

    assign off        = bus.addr - BASE_ADDR;
    assign op_sel     = bus.wrdata[NUM_FUNCS-1:0];
    assign op_onehot  = (op_sel != '0) && ((op_sel & (op_sel - NUM_FUNCS'(1))) == '0);
    assign push       = |(fpu_valids & RES_MASK);
    assign pop_req    = bus.rden && (off == OFF_RESULT);
    assign pop        = pop_req && !empty;
    assign push_entry = '{result: fpu_result, exc: exceptions, op_id: OP_ID_W'(fpu_valids)};

`ifdef FPU_RES_FIFO_EN
    logic full;

    fpu_res_fifo #(.DEPTH(RES_DEPTH)) u_res_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_entry),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    assign ovf_set = push && full && !pop;
`else
    res_entry_t hold_q, hold_d;
    logic       hold_vld_q, hold_vld_d;

    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        if (push) begin
            hold_d     = push_entry;
            hold_vld_d = 1'b1;
        end else if (pop) begin
            hold_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
        end
    end

    assign head    = hold_q;
    assign empty   = !hold_vld_q;
    assign level   = LVL_W'(hold_vld_q);
    assign ovf_set = push && hold_vld_q && !pop;
`endif

    always_comb begin
        ops_d       = ops_q;
        op_valids_d = '0;
        busy_d      = busy_q;
        frm_d       = frm_q;
        fflags_d    = fflags_q;
        irq_en_d    = irq_en_q;
        launch      = 1'b0;
        op_err_set  = 1'b0;
        w1c         = '0;
        if (bus.wren) begin
            for (int i = 0; i < NUM_OPS; i++) begin
                if (off == OFF_OPERAND0 + 32'(4 * i)) ops_d[i] = bus.wrdata;
            end
            case (off)
                OFF_OPERATION: begin
                    if (!busy_q && op_onehot) begin
                        op_valids_d = op_sel;
                        launch      = 1'b1;
                    end else begin
                        op_err_set  = 1'b1;
                    end
                end
                OFF_STATUS: w1c      = bus.wrdata[ST_OP_ERR:ST_OVERFLOW];
                OFF_IRQ_EN: irq_en_d = bus.wrdata[3:0];
                OFF_FFLAGS: fflags_d = bus.wrdata[4:0];
                OFF_FRM:    frm_d    = bus.wrdata[2:0];
                OFF_FCSR: begin
                    frm_d    = bus.wrdata[7:5];
                    fflags_d = bus.wrdata[4:0];
                end
                default: ;
            endcase
        end
        // A stray completion in the launch cycle must not hide the new op.
        if (|fpu_valids) busy_d = 1'b0;
        if (launch)      busy_d = 1'b1;
        if (push)        fflags_d = fflags_d | exceptions;
        ovf_d    = (ovf_q    && !w1c[ST_OVERFLOW])  || ovf_set;
        udf_d    = (udf_q    && !w1c[ST_UNDERFLOW]) || (pop_req && empty);
        op_err_d = (op_err_q && !w1c[ST_OP_ERR])    || op_err_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_OPS; i++) ops_q[i] <= '0;
            op_valids_q <= '0;
            busy_q      <= 1'b0;
            frm_q       <= '0;
            fflags_q    <= '0;
            irq_en_q    <= '0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            op_err_q    <= 1'b0;
        end else begin
            ops_q       <= ops_d;
            op_valids_q <= op_valids_d;
            busy_q      <= busy_d;
            frm_q       <= frm_d;
            fflags_q    <= fflags_d;
            irq_en_q    <= irq_en_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
            op_err_q    <= op_err_d;
        end
    end

    always_comb begin
        bus.rddata = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (off == OFF_OPERAND0 + 32'(4 * i)) bus.rddata = ops_q[i];
        end
        case (off)
            OFF_RESULT:   if (!empty) bus.rddata = head.result;
            OFF_RES_INFO: if (!empty) bus.rddata = {1'b0, head.op_id, 3'b000, head.exc};
            OFF_STATUS: begin
                bus.rddata[ST_DONE]      = !empty;
                bus.rddata[ST_OVERFLOW]  = ovf_q;
                bus.rddata[ST_UNDERFLOW] = udf_q;
                bus.rddata[ST_OP_ERR]    = op_err_q;
                bus.rddata[ST_BUSY]      = busy_q;
            end
            OFF_IRQ_EN:   bus.rddata[3:0]       = irq_en_q;
            OFF_FFLAGS:   bus.rddata[4:0]       = fflags_q;
            OFF_FRM:      bus.rddata[2:0]       = frm_q;
            OFF_FCSR:     bus.rddata[7:0]       = {frm_q, fflags_q};
            OFF_LEVEL:    bus.rddata[LVL_W-1:0] = level;
            default: ;
        endcase
    end

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_ops
        assign ops[32*g +: 32] = ops_q[g];
    end

    assign op_valids = op_valids_q;
    assign frm       = frm_q;
    assign busy      = busy_q;
    assign irq       = |({op_err_q, udf_q, ovf_q, !empty} & irq_en_q);
endmodule

// File: tb/tb_fpu_csr_bank.sv
// Scoreboard bench for fpu_csr_bank: stimulus queues expected reads, launch pulses and
// output probes; a negedge monitor pops and compares whenever the DUT presents them.
module tb_fpu_csr_bank;
    localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef FPU_RES_FIFO_EN
    localparam int DEPTH_EFF = 4;
`else
    localparam int DEPTH_EFF = 1;
`endif
    localparam logic [31:0] A_OP0 = 32'h00, A_OP1 = 32'h04, A_OP2 = 32'h08, A_OP3 = 32'h0C;
    localparam logic [31:0] A_RES = 32'h20, A_INFO = 32'h24, A_OPER = 32'h28, A_STAT = 32'h2C;
    localparam logic [31:0] A_IEN = 32'h30, A_FFL = 32'h34, A_FRM = 32'h38, A_FCSR = 32'h3C;
    localparam logic [31:0] A_LVL = 32'h40, A_BAD = 32'h44;
    localparam int K_IRQ = 0, K_BUSY = 1, K_FRM = 2, K_OPS = 3;

    typedef struct {
        string       name;
        logic [95:0] val;
        int          kind;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        probe = 1'b0;
    logic [95:0] ops;
    logic [12:0] op_valids;
    logic [2:0]  frm;
    logic [31:0] fpu_result;
    logic [12:0] fpu_valids;
    logic [4:0]  exceptions;
    logic        busy, irq;

    exp_t rd_q[$];
    exp_t ov_q[$];
    exp_t pr_q[$];
    int   total = 0;
    int   bad = 0;

    fpu_csr_bank_if bus();

    fpu_csr_bank #(
        .BASE_ADDR (BASE),
        .NUM_OPS   (3),
        .NUM_FUNCS (13),
        .RES_MASK  (13'h1FFC),
        .RES_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .ops        (ops),
        .op_valids  (op_valids),
        .frm        (frm),
        .fpu_result (fpu_result),
        .fpu_valids (fpu_valids),
        .exceptions (exceptions),
        .busy       (busy),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic flag(input string name, input logic [95:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %0h with nothing expected", name, act);
    endtask

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [95:0] act;
        if (bus.rden) begin
            if (rd_q.size() == 0) flag("rd_unexpected", 96'(bus.rddata));
            else begin
                e = rd_q.pop_front();
                check(e.name, 96'(bus.rddata), e.val);
            end
        end
        if (op_valids !== '0) begin
            if (ov_q.size() == 0) flag("op_valids_unexpected", 96'(op_valids));
            else begin
                e = ov_q.pop_front();
                check(e.name, 96'(op_valids), e.val);
            end
        end
        if (probe) begin
            if (pr_q.size() == 0) flag("probe_unexpected", '0);
            else begin
                e = pr_q.pop_front();
                case (e.kind)
                    K_IRQ:   act = 96'(irq);
                    K_BUSY:  act = 96'(busy);
                    K_FRM:   act = 96'(frm);
                    default: act = ops;
                endcase
                check(e.name, act, e.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr   = BASE + a;
        bus.wrdata = d;
        bus.wren   = 1'b1;
        tick();
        bus.wren   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] want, input string name);
        rd_q.push_back('{name, 96'(want), 0});
        bus.addr = BASE + a;
        bus.rden = 1'b1;
        tick();
        bus.rden = 1'b0;
    endtask

    task automatic drive_fpu(input logic [12:0] v, input logic [31:0] r, input logic [4:0] x);
        fpu_valids = v;
        fpu_result = r;
        exceptions = x;
    endtask

    task automatic fpu_done(input logic [12:0] v, input logic [31:0] r, input logic [4:0] x);
        drive_fpu(v, r, x);
        tick();
        drive_fpu('0, '0, '0);
    endtask

    task automatic expect_probe(input int kind, input logic [95:0] v, input string name);
        pr_q.push_back('{name, v, kind});
        probe = 1'b1;
        tick();
        probe = 1'b0;
    endtask

    task automatic expect_launch(input logic [12:0] v, input string name);
        ov_q.push_back('{name, 96'(v), 0});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.addr = '0; bus.wren = 1'b0; bus.rden = 1'b0; bus.wrdata = '0;
        drive_fpu('0, '0, '0);
        repeat (2) tick();
        expect_probe(K_OPS, '0, "rst_ops");
        expect_probe(K_BUSY, '0, "rst_busy");
        rst = 1'b0;
        rd(A_STAT, 32'h0, "rst_status");
        rd(A_LVL, 32'h0, "rst_level");
        rd(A_FCSR, 32'h0, "rst_fcsr");
        rd(A_IEN, 32'h0, "rst_irq_en");
        expect_probe(K_IRQ, '0, "rst_irq");

        // Basic add: operands, launch, completion, pop.
        wr(A_IEN, 32'h1);
        wr(A_OP0, 32'h3F80_0000);
        wr(A_OP1, 32'h4000_0000);
        wr(A_OP2, 32'hCAFE_F00D);
        wr(A_OP3, 32'hDEAD_BEEF);
        wr(A_BAD, 32'h1234_5678);
        rd(A_OP0, 32'h3F80_0000, "op0_rb");
        rd(A_OP3, 32'h0, "unmapped_op3");
        rd(A_BAD, 32'h0, "unmapped_0x44");
        expect_probe(K_OPS, {32'hCAFE_F00D, 32'h4000_0000, 32'h3F80_0000}, "ops_out");
        expect_launch(13'h0004, "launch_add");
        wr(A_OPER, 32'h0004);
        expect_probe(K_BUSY, 96'd1, "busy_after_launch");
        rd(A_STAT, 32'h10, "status_busy");
        rd(A_OPER, 32'h0, "operation_wo");
        expect_probe(K_IRQ, '0, "irq_before_done");
        fpu_done(13'h0004, 32'h4040_0000, 5'h01);
        expect_probe(K_BUSY, '0, "busy_cleared");
        expect_probe(K_IRQ, 96'd1, "irq_done");
        rd(A_STAT, 32'h01, "status_done");
        rd(A_LVL, 32'h1, "level_one");
        rd(A_INFO, 32'h0000_0401, "res_info");
        rd(A_RES, 32'h4040_0000, "result_add");
        rd(A_FFL, 32'h01, "fflags_accrued");
        rd(A_STAT, 32'h00, "status_after_pop");
        expect_probe(K_IRQ, '0, "irq_after_pop");

        // Launch errors: while busy, non-one-hot, zero.
        expect_launch(13'h0008, "launch_second");
        wr(A_OPER, 32'h0008);
        wr(A_OPER, 32'h0010);
        rd(A_STAT, 32'h18, "status_op_err_busy");
        wr(A_STAT, 32'h8);
        rd(A_STAT, 32'h10, "status_op_err_cleared");
        fpu_done(13'h0008, 32'h1111_1111, 5'h00);
        rd(A_RES, 32'h1111_1111, "result_second");
        wr(A_OPER, 32'h0006);
        rd(A_STAT, 32'h08, "status_op_err_multihot");
        wr(A_STAT, 32'h8);
        wr(A_OPER, 32'h0000);
        rd(A_STAT, 32'h08, "status_op_err_zero");
        wr(A_STAT, 32'h8);
        expect_launch(13'h0001, "launch_nores");
        wr(A_OPER, 32'h0001);
        fpu_done(13'h0001, 32'h0000_0077, 5'h00);
        rd(A_STAT, 32'h00, "status_nores_done");
        rd(A_LVL, 32'h0, "level_nores");

        // Overflow: five results, then a sixth coinciding with W1C of overflow.
        for (int k = 0; k < 5; k++) fpu_done(13'h0004, 32'hA000_0000 + k, 5'h00);
        rd(A_LVL, 32'(DEPTH_EFF), "level_full");
        rd(A_STAT, 32'h03, "status_overflow");
        drive_fpu(13'h0004, 32'hA000_0005, 5'h00);
        wr(A_STAT, 32'h2);
        drive_fpu('0, '0, '0);
        rd(A_STAT, 32'h03, "status_w1c_vs_set");
        wr(A_STAT, 32'h2);
        rd(A_STAT, 32'h01, "status_ovf_cleared");
`ifdef FPU_RES_FIFO_EN
        for (int k = 0; k < 4; k++) rd(A_RES, 32'hA000_0000 + k, "result_order");
`else
        rd(A_RES, 32'hA000_0005, "result_overwrite");
`endif
        rd(A_LVL, 32'h0, "level_drained");

        // Underflow and its irq source.
        rd(A_RES, 32'h0, "underflow_data");
        rd(A_STAT, 32'h04, "status_underflow");
        rd(A_LVL, 32'h0, "level_after_underflow");
        expect_probe(K_IRQ, '0, "irq_udf_masked");
        wr(A_IEN, 32'h4);
        expect_probe(K_IRQ, 96'd1, "irq_udf_enabled");
        wr(A_STAT, 32'h4);
        expect_probe(K_IRQ, '0, "irq_udf_cleared");
        wr(A_IEN, 32'h1);

        // Full queue with a same-cycle pop and push.
        for (int k = 0; k < DEPTH_EFF; k++) fpu_done(13'h0004, 32'hB000_0000 + k, 5'h00);
        rd(A_STAT, 32'h01, "status_full_no_ovf");
        drive_fpu(13'h0004, 32'hBEEF_0000, 5'h00);
        rd(A_RES, 32'hB000_0000, "pop_push_head");
        drive_fpu('0, '0, '0);
        rd(A_LVL, 32'(DEPTH_EFF), "level_pop_push");
        rd(A_STAT, 32'h01, "status_pop_push");
`ifdef FPU_RES_FIFO_EN
        rd(A_RES, 32'hB000_0001, "pop_push_next");
`else
        rd(A_RES, 32'hBEEF_0000, "pop_push_next");
`endif

        // FCSR write coinciding with an accrue.
        drive_fpu(13'h0004, 32'hC000_0000, 5'h04);
        wr(A_FCSR, 32'hE0);
        drive_fpu('0, '0, '0);
        rd(A_FCSR, 32'hE4, "fcsr_accrue");
        rd(A_FRM, 32'h7, "frm_rb");
        rd(A_FFL, 32'h04, "fflags_after_fcsr");
        expect_probe(K_FRM, 96'd7, "frm_out");

        // Reset mid-operation, then a late completion.
        expect_launch(13'h0004, "launch_before_rst");
        wr(A_OPER, 32'h0004);
        expect_probe(K_BUSY, 96'd1, "busy_before_rst");
        rst = 1'b1;
        tick();
        expect_probe(K_OPS, '0, "rst2_ops");
        expect_probe(K_BUSY, '0, "rst2_busy");
        expect_probe(K_IRQ, '0, "rst2_irq");
        expect_probe(K_FRM, '0, "rst2_frm");
        rd(A_STAT, 32'h0, "rst2_status");
        rst = 1'b0;
        rd(A_LVL, 32'h0, "rst2_level");
        rd(A_FCSR, 32'h0, "rst2_fcsr");
        rd(A_IEN, 32'h0, "rst2_irq_en");
        fpu_done(13'h0004, 32'h0000_0055, 5'h02);
        rd(A_LVL, 32'h1, "late_level");
        rd(A_STAT, 32'h01, "late_status");
        rd(A_RES, 32'h0000_0055, "late_result");
        rd(A_FFL, 32'h02, "late_fflags");

        repeat (3) tick();
        check("rd_queue_drained", 96'(rd_q.size()), '0);
        check("launch_queue_drained", 96'(ov_q.size()), '0);
        check("probe_queue_drained", 96'(pr_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fpu_csr_bank.md
# fpu_csr_bank

Parametrised memory-mapped control/status bank for the FPU wrapper, sitting between the Wishbone slave decode and the FPU datapath. It holds NUM_OPS operand registers, launches one operation at a time with a start pulse and busy tracking, and queues results with their exception flags and op ID in a result FIFO popped by host reads. It accrues RISC-V fflags and drives a maskable level interrupt from done and sticky error sources.

## Interface
- BASE_ADDR, 32'h3000_0000: register window base.
- NUM_OPS, 3: operand registers, 1..8.
- NUM_FUNCS, 13: width of op select / valid vectors.
- RES_MASK, 13'h1FFC: fpu_valids bits that produce a result and push the FIFO.
- RES_DEPTH, 4: result FIFO entries, power of two, ≥2.
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- addr  in  32  host word address.
- wren  in  1  host write strobe.
- rden  in  1  host read strobe; qualifies pop side effects.
- wrdata  in  32  host write data.
- rddata  out  32  combinational read data for addr.
- ops  out  NUM_OPS*32  operand i at [32*i+31:32*i].
- op_valids  out  NUM_FUNCS  one-cycle one-hot launch pulse to FPU.
- frm  out  3  rounding mode.
- fpu_result  in  32  FPU result.
- fpu_valids  in  NUM_FUNCS  FPU completion, one-hot.
- exceptions  in  5  flags for the completing op.
- busy  out  1  operation in flight.
- irq  out  1  level interrupt.

## Operation
- Map (offset from BASE_ADDR): 0x00+4i OPERAND_i RW; 0x20 RESULT RO pop; 0x24 RES_INFO RO {op_id[NUM_FUNCS-1:0] at [20:8], exc[4:0]} of head, no pop; 0x28 OPERATION WO; 0x2C STATUS; 0x30 IRQ_EN RW [3:0]; 0x34 FFLAGS; 0x38 FRM; 0x3C FCSR {frm,fflags}; 0x40 LEVEL RO. Unmapped reads return 0; unmapped writes are ignored.
- OPERATION write, busy=0: op_valids = wrdata[NUM_FUNCS-1:0] for exactly one cycle; busy set. Write while busy, or with zero/non-one-hot data: no launch, STATUS.op_err set.
- Completion: any fpu_valids bit clears busy. If (fpu_valids & RES_MASK)≠0, push {fpu_result, exceptions, fpu_valids}; fflags |= exceptions.
- RESULT read (rden & addr match): returns head result and pops. Empty: returns 0, no pop, sets underflow.
- Push when full and no same-cycle pop: entry dropped, overflow set. Push and pop in the same cycle when full: both take effect, no overflow.
- STATUS: [0] done = FIFO non-empty (RO, level); [1] overflow, [2] underflow, [3] op_err, all sticky W1C; [4] busy RO.
- irq = |(STATUS[3:0] & IRQ_EN[3:0]).
- FFLAGS/FCSR write with same-cycle accrue: fflags = wrdata-field | exceptions. A W1C write coinciding with a new set event leaves the bit set.

## Timing
- All state updates at the posedge following the strobe; rddata is combinational in the same cycle.
- Launch: op_valids asserted in the cycle after the OPERATION write; busy rises with it.
- Result is readable at RESULT the cycle after the fpu_valids cycle; irq rises in that cycle too.
- Reset: ops, op_valids, frm, fflags, busy, irq, IRQ_EN, STATUS, FIFO pointers and LEVEL all 0. Reset mid-operation discards in-flight tracking; a late fpu_valids pulse after reset is pushed normally.

## Configuration
- FPU_RES_FIFO_EN defined: RES_DEPTH-entry FIFO as above.
- FPU_RES_FIFO_EN undefined: single holding entry; a push while valid overwrites it and sets overflow. Pop, done, and LEVEL (0/1) semantics are unchanged.

## Structure
- fpu_csr_pkg: register offset localparams, STATUS bit indices, res_entry_t struct {result, exc, op_id}.
- Sub-module fpu_res_fifo: parametrised depth, push/pop/full/empty/level, wrap-around pointers with an extra MSB. Instantiated only under FPU_RES_FIFO_EN.

## Test plan
- Write OPERAND_0=0x3F800000 and OPERAND_1=0x40000000, then OPERATION=0x0004 -> op_valids=0x0004 for one cycle, busy=1. Return fpu_valids=0x0004 with result 0x40400000 and exc 0x01 -> busy=0, irq=1 (IRQ_EN=1), RESULT reads 0x40400000, FFLAGS=0x01, done=0 after the pop.
- Write OPERATION while busy -> no op_valids pulse; op_err=1. W1C 0x8 to STATUS -> op_err=0.
- Issue 5 results with RES_DEPTH=4 and no reads -> LEVEL=4, overflow=1, and reads return the first four results in order.
- Read RESULT when empty -> rddata=0, underflow=1, LEVEL stays 0.
- FIFO full, with a RESULT read and a push in the same cycle -> LEVEL stays 4, no overflow; the next read returns the second entry.
- FCSR write 0xE0 coinciding with exc 0x04 -> frm=7, fflags=0x04. Then assert rst mid-operation -> all outputs 0 next cycle.
